muldiv_unit: RTL and testbench

Multi-cycle integer multiply/divide unit downstream of the register file `rf`. It consumes the two read ports (rd1 as operand a, rd2 as operand b) and produces a 64-bit hi/lo result. lo, or hi for remainder/upper-product moves, is returned to `rf` via wd on a later write. Iterative datapath: one result bit per cycle, so it is small but takes a fixed number of cycles.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_negate.sv | 13 +
 rtl/muldiv_unit.sv | 115 +++++++++++
 tb/tb_muldiv_unit.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit and
// the decoder that drives its op field.
//   OP_*      : op encodings (bit 0 = signed, bit 1 = divide)
//   ST_*      : muldiv_unit FSM states
//   WIDTH_DEF : default operand width
package muldiv_pkg;
  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'd0,
    OP_MULT  = 2'd1,
    OP_DIVU  = 2'd2,
    OP_DIV   = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;
endpackage

// File: rtl/muldiv_negate.sv
// muldiv_negate: combinational conditional two's-complement negator.
//   in  [W-1:0] : value
//   en          : 1 = output -in, 0 = pass through
//   out [W-1:0] : result
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] in,
  input  logic         en,
  output logic [W-1:0] out
);
  assign out = en ? -in : in;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative integer multiply/divide, one result bit per cycle.
// Signed ops run on operand magnitudes and are sign-corrected in FIX.
//   clk, reset : clock, synchronous active-high reset
//   start      : request, accepted only in IDLE
//   op         : OP_MULTU / OP_MULT / OP_DIVU / OP_DIV
//   a, b       : operand a / dividend, operand b / divisor
//   busy       : high outside IDLE
//   done       : one-cycle pulse, hi/lo valid from this cycle
//   hi, lo     : product upper/lower half, or remainder/quotient
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);

  state_t             state;
  op_t                op_q;
  logic               sa, sb, bz;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   ma;   // |a|; reused as dividend/quotient shift register
  logic [WIDTH-1:0]   mb;   // |b|
  logic [2*WIDTH-1:0] acc;  // multiply accumulator, multiplier in low half
  logic [WIDTH-1:0]   rem;  // divider partial remainder (always < mb)

  // operand magnitudes, only for the signed ops
  logic [WIDTH-1:0] abs_a, abs_b;
  muldiv_negate #(.W(WIDTH)) u_neg_a (.in(a), .en(op[0] & a[WIDTH-1]), .out(abs_a));
  muldiv_negate #(.W(WIDTH)) u_neg_b (.in(b), .en(op[0] & b[WIDTH-1]), .out(abs_b));

  // multiply step: conditional add into the upper half with carry, then shift right
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_nxt;
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, ma} : '0);
  assign acc_nxt = {mul_sum, acc[WIDTH-1:1]};

  // restoring divide step; the shifted remainder needs WIDTH+1 bits, the
  // restored one fits back in WIDTH bits because it is below mb
  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] rem_nxt;
  assign rem_sh  = {rem, ma[WIDTH-1]};
  assign ge      = rem_sh >= {1'b0, mb};
  assign rem_nxt = ge ? (rem_sh[WIDTH-1:0] - mb) : rem_sh[WIDTH-1:0];

  // sign fixups; remainder follows the dividend, which also makes b==0 give hi=a
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  muldiv_negate #(.W(2*WIDTH)) u_neg_p (.in(acc), .en(op_q == OP_MULT && (sa ^ sb)), .out(prod_fix));
  muldiv_negate #(.W(WIDTH))   u_neg_q (.in(ma),  .en(op_q == OP_DIV  && (sa ^ sb)), .out(quo_fix));
  muldiv_negate #(.W(WIDTH))   u_neg_r (.in(rem), .en(op_q == OP_DIV  && sa),        .out(rem_fix));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
    end else begin
      // registered pulse: lands in the cycle after the DONE state
      done <= (state == ST_DONE);
      case (state)
        ST_IDLE: if (start) begin
          op_q  <= op_t'(op);
          sa    <= a[WIDTH-1];
          sb    <= b[WIDTH-1];
          bz    <= (b == '0);
          ma    <= abs_a;
          mb    <= abs_b;
          acc   <= {{WIDTH{1'b0}}, abs_b};
          rem   <= '0;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (op_q[1]) begin
            rem <= rem_nxt;
            ma  <= {ma[WIDTH-2:0], ge};
          end else begin
            acc <= acc_nxt;
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= ST_FIX;
        end
        ST_FIX: begin
          if (op_q[1]) begin
            lo <= bz ? '1 : quo_fix;
            hi <= rem_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          state <= ST_DONE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit (WIDTH=32) with latency,
// busy and done-pulse checks, plus hand sequences for mid-operation start,
// mid-operation reset and back-to-back throughput.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // called at posedge+1; issues one op and watches 40 cycles after acceptance
  task automatic run_op(input logic [1:0] o, input logic [31:0] xa, xb, eh, el, input string nm);
    int first, ndone, nbusy;
    op = o; a = xa; b = xb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
    first = -1; ndone = 0; nbusy = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (first < 0) first = c;
      end
      @(posedge clk); #1;
    end
    chk({nm, ".lat"}, first, 34);
    chk({nm, ".ndone"}, ndone, 1);
    chk({nm, ".nbusy"}, nbusy, 34);
    chk({nm, ".hi"}, hi, eh);
    chk({nm, ".lo"}, lo, el);
  endtask

  initial begin
    int first, second, ndone;
    logic [31:0] sq;

    tv[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    tv[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    tv[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    tv[3]  = '{OP_DIVU,  32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF};
    tv[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    tv[5]  = '{OP_MULTU, 32'd6,        32'd7,        32'h00000000, 32'd42};
    tv[6]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    tv[7]  = '{OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
    tv[8]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    tv[9]  = '{OP_MULT,  32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF};
    tv[10] = '{OP_DIVU,  32'd625,      32'd16,       32'h00000001, 32'd39};
    tv[11] = '{OP_MULTU, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.hi", hi, 0);
    chk("rst.lo", lo, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++)
      run_op(tv[i].op, tv[i].a, tv[i].b, tv[i].hi, tv[i].lo, $sformatf("vec%0d", i));

    // start re-asserted while busy is ignored
    op = OP_MULTU; a = 32'd6; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    first = -1; ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (c == 5) begin start = 1'b1; a = 32'd1; b = 32'd1; end
      else start = 1'b0;
      if (done) begin ndone++; if (first < 0) first = c; end
      @(posedge clk); #1;
    end
    chk("busy_start.lat", first, 34);
    chk("busy_start.ndone", ndone, 1);
    chk("busy_start.hi", hi, 0);
    chk("busy_start.lo", lo, 42);

    // reset mid-operation aborts with reset values and no late completion
    op = OP_MULTU; a = 32'd6; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    chk("abort.hi", hi, 0);
    chk("abort.lo", lo, 0);
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      if (done || busy) ndone++;
      @(posedge clk); #1;
    end
    chk("abort.quiet", ndone, 0);
    run_op(OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, "after_abort");

    // start held high: ignored in DONE, next op accepted W+3 cycles later
    op = OP_MULTU; a = 32'd6; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    first = -1; second = -1; ndone = 0;
    for (int c = 0; c < 75; c++) begin
      if (done) begin
        ndone++;
        if (first < 0) first = c; else if (second < 0) second = c;
      end
      if (c == 69) start = 1'b0;
      @(posedge clk); #1;
    end
    chk("b2b.first", first, 34);
    chk("b2b.second", second, 69);
    chk("b2b.ndone", ndone, 2);
    chk("b2b.idle", busy, 0);

    // register-file squares divided by 4
    for (int i = 0; i < 32; i++) begin
      sq = 32'(i * i);
      run_op(OP_DIVU, sq, 32'd4, sq % 4, sq / 4, $sformatf("sq%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
